// File: rtl/cpu_pkg.sv
// cpu_pkg: shared divider defaults and div_sequencer state encoding
package cpu_pkg;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int DIV_LATENCY_DEF = 8;
  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_CAPTURE,
    S_DONE
  } div_state_e;
endpackage

// File: rtl/div_sequencer_latency_counter.sv
// latency_counter: loadable down-counter with zero flag, parked at zero
module latency_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             zero
);
  assign zero = count == '0;
  // load wins over decrement; never wraps below zero
  always_ff @(posedge clock) begin
    if (reset) count <= '0;
    else if (load) count <= value;
    else if (dec && !zero) count <= count - 1'b1;
  end
endmodule

// File: rtl/div_sequencer.sv
// div_sequencer: drives a pipelined divider through clear/run/capture with a busy/done handshake (optional DIV_ZERO_CHECK_EN)
module div_sequencer
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DIV_LATENCY = DIV_LATENCY_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] numer,
  input  logic [DATA_WIDTH-1:0] denom,
  output logic [DATA_WIDTH-1:0] div_numer,
  output logic [DATA_WIDTH-1:0] div_denom,
  output logic                  dclken,
  output logic                  daclr,
  input  logic [DATA_WIDTH-1:0] divq,
  input  logic [DATA_WIDTH-1:0] divr,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] quot,
  output logic [DATA_WIDTH-1:0] rem,
  output logic                  dz_err
);
  localparam int CW = $clog2(DIV_LATENCY + 1);
  if (DIV_LATENCY < 1 || DIV_LATENCY > 64) begin : g_bad_latency
    $error("div_sequencer: DIV_LATENCY must be within 1..64");
  end
  div_state_e state, state_n;
  logic [CW-1:0] count;
  logic zero;
  logic dz_start, dz_cap;
`ifdef DIV_ZERO_CHECK_EN
  assign dz_start = denom == '0;
  assign dz_cap = div_denom == '0;
`else
  assign dz_start = 1'b0;
  assign dz_cap = 1'b0;
`endif
  latency_counter #(.WIDTH(CW)) u_cnt (
    .clock(clock),
    .reset(reset),
    .load(state == S_CLEAR),
    .value(CW'(DIV_LATENCY - 1)),
    .dec(state == S_RUN),
    .count(count),
    .zero(zero)
  );
  // next state; a zero denominator (when checked) bypasses the divider entirely
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:    state_n = start ? (dz_start ? S_CAPTURE : S_CLEAR) : S_IDLE;
      S_CLEAR:   state_n = S_RUN;
      S_RUN:     state_n = zero ? S_CAPTURE : S_RUN;
      S_CAPTURE: state_n = S_DONE;
      default:   state_n = S_IDLE;
    endcase
  end
  // state plus registered outputs decoded from the upcoming state
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      div_numer <= '0;
      div_denom <= '0;
      quot <= '0;
      rem <= '0;
      dclken <= 1'b0;
      daclr <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
      dz_err <= 1'b0;
    end else begin
      state <= state_n;
      dclken <= state_n == S_RUN;
      daclr <= state_n == S_CLEAR;
      busy <= state_n != S_IDLE;
      done <= state_n == S_DONE;
      if (state == S_IDLE && start) begin
        div_numer <= numer;
        div_denom <= denom;
        dz_err <= 1'b0;
      end
      if (state == S_CAPTURE) begin
        quot <= dz_cap ? '1 : divq;
        rem <= dz_cap ? div_numer : divr;
        dz_err <= dz_cap;
      end
    end
  end
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: checks div_sequencer against a pipelined divider model and arithmetic expectations
module tb_div_sequencer;
  localparam int W = 16;
  localparam int L = 4;
  logic clock = 1'b0;
  logic reset, start;
  logic [W-1:0] numer, denom, div_numer, div_denom, divq, divr, quot, rem;
  logic dclken, daclr, busy, done, dz_err;
  int total = 0;
  int bad = 0;
  logic [W-1:0] pq [L];
  logic [W-1:0] pr [L];

  div_sequencer #(.DATA_WIDTH(W), .DIV_LATENCY(L)) dut (
    .clock(clock), .reset(reset), .start(start), .numer(numer), .denom(denom),
    .div_numer(div_numer), .div_denom(div_denom), .dclken(dclken), .daclr(daclr),
    .divq(divq), .divr(divr), .busy(busy), .done(done), .quot(quot), .rem(rem),
    .dz_err(dz_err)
  );

  always #5 clock = ~clock;

  // divider megafunction model: L-stage pipeline, advances on dclken, cleared by daclr
  always @(posedge clock) begin
    if (daclr) begin
      for (int i = 0; i < L; i++) begin
        pq[i] <= '0;
        pr[i] <= '0;
      end
    end else if (dclken) begin
      pq[0] <= (div_denom == 0) ? '1 : div_numer / div_denom;
      pr[0] <= (div_denom == 0) ? div_numer : div_numer % div_denom;
      for (int i = 1; i < L; i++) begin
        pq[i] <= pq[i-1];
        pr[i] <= pr[i-1];
      end
    end
  end
  assign divq = pq[L-1];
  assign divr = pr[L-1];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // one divide: lat counts the accept edge as edge 1 up to the edge that raises done
  task automatic do_op(input logic [W-1:0] n, input logic [W-1:0] d, input logic [W-1:0] q,
                       input logic [W-1:0] r, input bit chkv, input int lat, input int en,
                       input int clr, input int first_en, input bit dz, input bit noise);
    int t, nen, nclr, nidle, fen, extra;
    numer = n;
    denom = d;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_accept", int'(busy), 1);
    numer = W'($urandom);
    denom = W'($urandom);
    t = 0; nen = 0; nclr = 0; nidle = 0; fen = -1;
    while (!done && t < 100) begin
      if (dclken && fen < 0) fen = t;
      nen += int'(dclken);
      nclr += int'(daclr);
      nidle += int'(!busy);
      start = noise && (t == 1 || t == 4);
      tick();
      t++;
    end
    start = 1'b0;
    chk("done_seen", int'(done), 1);
    chk("latency", t + 1, lat);
    chk("dclken_cycles", nen, en);
    chk("dclken_first", fen, first_en);
    chk("daclr_cycles", nclr, clr);
    chk("busy_gaps", nidle, 0);
    chk("busy_at_done", int'(busy), 1);
    chk("div_numer_held", int'(div_numer), int'(n));
    chk("div_denom_held", int'(div_denom), int'(d));
    chk("dz_err", int'(dz_err), int'(dz));
    if (chkv) begin
      chk("quot", int'(quot), int'(q));
      chk("rem", int'(rem), int'(r));
    end
    tick();
    chk("done_pulse", int'(done), 0);
    chk("busy_released", int'(busy), 0);
    if (noise) begin
      extra = 0;
      for (int i = 0; i < L + 6; i++) begin
        extra += int'(done) + int'(busy);
        tick();
      end
      chk("noise_no_second_op", extra, 0);
    end
  endtask

  typedef struct {
    logic [W-1:0] n;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic [W-1:0] r;
  } vec_t;

  initial begin
    vec_t vecs [6];
    int t, cnt;
    logic [W-1:0] n, d;
    vecs[0] = '{16'd100, 16'd7, 16'd14, 16'd2};
    vecs[1] = '{16'hFFFF, 16'd1, 16'hFFFF, 16'd0};
    vecs[2] = '{16'd5, 16'd9, 16'd0, 16'd5};
    vecs[3] = '{16'd9, 16'd3, 16'd3, 16'd0};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 16'd1, 16'd0};
    vecs[5] = '{16'd0, 16'd5, 16'd0, 16'd0};
    reset = 1'b1; start = 1'b0; numer = '0; denom = '0;
    tick(); tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_dclken", int'(dclken), 0);
    chk("rst_daclr", int'(daclr), 1);
    chk("rst_quot", int'(quot), 0);
    chk("rst_dz_err", int'(dz_err), 0);
    reset = 1'b0;
    tick();
    chk("daclr_after_release", int'(daclr), 0);

    for (int i = 0; i < 6; i++) begin
      do_op(vecs[i].n, vecs[i].d, vecs[i].q, vecs[i].r, 1'b1, L + 3, L, 1, 1, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) tick();
      chk("quot_hold", int'(quot), int'(vecs[i].q));
      chk("rem_hold", int'(rem), int'(vecs[i].r));
    end

    do_op(16'd1234, 16'd11, 16'd112, 16'd2, 1'b1, L + 3, L, 1, 1, 1'b0, 1'b1);

    for (int i = 0; i < 16; i++) begin
      n = W'($urandom);
      d = (i % 3 == 0) ? W'($urandom_range(1, 15)) : W'($urandom_range(1, 65535));
      do_op(n, d, n / d, n % d, 1'b1, L + 3, L, 1, 1, 1'b0, 1'b0);
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) tick();
    end

    numer = 16'd1000; denom = 16'd10; start = 1'b1;
    t = 0;
    while (!done && t < 100) begin tick(); t++; end
    chk("held_first_done", int'(done), 1);
    tick();
    t = 1;
    while (!done && t < 100) begin tick(); t++; end
    chk("held_period", t, L + 4);
    chk("held_quot", int'(quot), 100);
    start = 1'b0;
    tick();
    tick();
    chk("held_released_idle", int'(busy), 0);

    numer = 16'd77; denom = 16'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_dclken", int'(dclken), 0);
    chk("midrst_daclr", int'(daclr), 1);
    chk("midrst_quot", int'(quot), 0);
    chk("midrst_rem", int'(rem), 0);
    chk("midrst_div_numer", int'(div_numer), 0);
    cnt = 0;
    for (int i = 0; i < 2 * L + 8; i++) begin
      tick();
      cnt += int'(done);
    end
    chk("midrst_no_done", cnt, 0);

`ifdef DIV_ZERO_CHECK_EN
    do_op(16'd42, 16'd0, 16'hFFFF, 16'd42, 1'b1, 2, 0, 0, -1, 1'b1, 1'b0);
    tick();
    chk("dz_err_sticky", int'(dz_err), 1);
    do_op(16'd9, 16'd3, 16'd3, 16'd0, 1'b1, L + 3, L, 1, 1, 1'b0, 1'b0);
`else
    do_op(16'd42, 16'd0, 16'd0, 16'd0, 1'b0, L + 3, L, 1, 1, 1'b0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
